// File: rtl/byte_gather_ctrl.sv
// rtl/byte_gather_ctrl.sv - sequences a registered 4-to-1 byte mux and packs four lanes into one word
module byte_gather_ctrl #(
    parameter int ORDER       = 0,
    parameter int CHECK_UPPER = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [1:0]  select,
    input  logic [31:0] mux_o,
    output logic [31:0] word,
    output logic        word_err,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        tag1_vld_q, tag1_vld_d;
    logic [1:0]  tag1_idx_q, tag1_idx_d;
    logic        tag2_vld_q;
    logic [1:0]  tag2_idx_q;
    logic [31:0] gather_q, gather_d;
    logic        err_acc_q, err_acc_d;
    logic [31:0] word_q, word_d;
    logic        word_err_q, word_err_d;
    logic        word_valid_q, word_valid_d;

    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic        upper_bad;
    logic        gather_done;

    // Byte position of the lane currently aligned with mux_o.
    always_comb begin
        lane_shift = 5'd0;
        if (ORDER == 0) begin
            lane_shift = {tag2_idx_q, 3'b000};
        end else begin
            lane_shift = 5'd24 - {tag2_idx_q, 3'b000};
        end
        lane_mask = 32'h0000_00FF << lane_shift;
        lane_data = {24'h00_0000, mux_o[7:0]} << lane_shift;
        upper_bad = (CHECK_UPPER != 0) && (mux_o[31:8] != 24'h00_0000);
    end

    assign gather_done = (state_q == ST_RUN) && tag2_vld_q && (tag2_idx_q == 2'd3);

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        sel_d        = 2'd0;
        tag1_vld_d   = 1'b0;
        tag1_idx_d   = 2'd0;
        gather_d     = gather_q;
        err_acc_d    = err_acc_q;
        word_d       = word_q;
        word_err_d   = word_err_q;
        word_valid_d = word_valid_q;

        if (tag2_vld_q) begin
            gather_d  = (gather_q & ~lane_mask) | lane_data;
            err_acc_d = err_acc_q | upper_bad;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    sel_d       = 2'd0;
                    tag1_vld_d  = 1'b1;
                    tag1_idx_d  = 2'd0;
                    issue_cnt_d = 3'd1;
                    gather_d    = 32'h0000_0000;
                    err_acc_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (issue_cnt_q < 3'd4) begin
                    sel_d       = issue_cnt_q[1:0];
                    tag1_vld_d  = 1'b1;
                    tag1_idx_d  = issue_cnt_q[1:0];
                    issue_cnt_d = issue_cnt_q + 3'd1;
                end
                // Final lane merges into the presented word on the same edge it is captured.
                if (gather_done) begin
                    state_d      = ST_HOLD;
                    issue_cnt_d  = 3'd0;
                    word_d       = gather_d;
                    word_err_d   = err_acc_d;
                    word_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    state_d      = ST_IDLE;
                    word_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= 3'd0;
            sel_q        <= 2'd0;
            tag1_vld_q   <= 1'b0;
            tag1_idx_q   <= 2'd0;
            tag2_vld_q   <= 1'b0;
            tag2_idx_q   <= 2'd0;
            gather_q     <= 32'h0000_0000;
            err_acc_q    <= 1'b0;
            word_q       <= 32'h0000_0000;
            word_err_q   <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            sel_q        <= sel_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_idx_q   <= tag1_idx_d;
            tag2_vld_q   <= tag1_vld_q;
            tag2_idx_q   <= tag1_idx_q;
            gather_q     <= gather_d;
            err_acc_q    <= err_acc_d;
            word_q       <= word_d;
            word_err_q   <= word_err_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign select     = sel_q;
    assign word       = word_q;
    assign word_err   = word_err_q;
    assign word_valid = word_valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/byte_gather_ctrl.md
Name: byte_gather_ctrl

Overview:
Sequencing stage wrapped around the 4-to-1 registered byte mux.
- Drives the mux `select` through lanes 0..3.
- Captures the mux's 32-bit zero-extended result two clock edges after each select is issued.
- Packs the four low bytes into one 32-bit word.
- Presents the word to downstream logic over a valid/ready handshake.
- Optionally flags any captured result whose upper 24 bits are non-zero.

Parameters:
- ORDER, 0, lane placement: 0 = lane k in word[8k+7:8k]; 1 = lane k in word[31-8k:24-8k].
- CHECK_UPPER, 1, 1 = set word_err when any captured mux_o[31:8] != 0; 0 = word_err tied 0.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one 4-byte gather; sampled only in IDLE.
- select  output  2  lane select driven to the mux; registered.
- mux_o  input  32  registered mux output.
- word  output  32  assembled word; stable while word_valid=1.
- word_err  output  1  upper-bits error for the presented word.
- word_valid  output  1  word available.
- word_ready  input  1  downstream accepts word.
- busy  output  1  high in RUN and HOLD.

Behaviour:
- Reset values (reset=1 at a rising edge):
  - select=0, word=0, word_err=0, word_valid=0, busy=0.
  - State = IDLE; issue counter = 0.
  - Both tag stages invalid; any in-flight gather is discarded.
- States:
  - IDLE: busy=0, select=0. start=1 at edge E0 -> RUN.
  - RUN: issue and capture.
  - HOLD: word_valid=1, waiting for word_ready.
- Issue, in RUN:
  - Edges E0..E3 load select with 0,1,2,3.
  - Tag stage 1 is loaded with {valid=1, idx=select value} on the same edges.
  - From E4 on, select=0 and tag1 is invalid.
- Alignment:
  - Each edge, tag2 <= tag1.
  - Mux latency is one edge, so while tag2 is valid, mux_o holds the result for lane tag2.idx.
- Capture:
  - At each edge with tag2 valid, lane tag2.idx of the internal word <= mux_o[7:0].
  - If CHECK_UPPER=1 and mux_o[31:8] != 0, the error flag is set (sticky).
  - Captures occur at E2..E5.
- Completion:
  - At E5, the final capture occurs and state -> HOLD.
  - word, word_err and word_valid=1 are visible in the cycle after E5.
  - Latency from start sampled to word_valid is 6 edges.
- Handshake:
  - At an edge with word_valid=1 and word_ready=1: word_valid <= 0, state -> IDLE.
  - word and word_err keep their last value until the next completion.
  - word_ready is ignored when word_valid=0.
- start outside IDLE is ignored and not queued, including in the handshake-completion cycle. Back-to-back gathers therefore have a gap of at least 1 cycle in IDLE.
- The error flag clears on start acceptance, not at the handshake.
- Throughput: one word per 7 cycles minimum with word_ready held high.
- Reset mid-RUN or mid-HOLD:
  - Takes effect at that edge; no partial word is ever presented.
  - The mux's own output register is not reset; stale mux_o is never captured because tags are invalid.
- The block does not inspect mux_o in IDLE or HOLD.

Test Plan:
- Reset, then mux inputs i0..i3 = 0x11,0x22,0x33,0x44, ORDER=0, start pulse with word_ready=1 -> select sequence 0,1,2,3 on consecutive cycles; word_valid high 6 edges after start; word=0x44332211; word_err=0; busy low one cycle after the handshake.
- Same stimulus with ORDER=1 -> word=0x11223344.
- Hold word_ready=0 for 5 cycles after word_valid rises, and pulse start during HOLD -> word_valid stays high; word is stable; start is ignored; exactly one word is delivered after word_ready rises.
- Force mux_o=0x00000155 on lane 2's capture cycle with CHECK_UPPER=1 -> word_err=1 with the word. The next clean gather -> word_err=0. With CHECK_UPPER=0 -> word_err=0.
- Assert reset at E3 of a gather, then start a new gather with i0..i3 = 0xA0..0xA3 -> no word_valid from the aborted gather; new word=0xA3A2A1A0.
- word_ready held high, start held high continuously -> words complete every 7 cycles, each equal to 0x44332211.
